lcd_bus_scheduler: RTL

LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_timer.sv | 24 ++
 rtl/lcd_bus_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus scheduler: state encoding, default
// timing counts (50 MHz clock) and the long-command decode.
package lcd_pkg;

  localparam int CNT_W = 21;

  localparam int unsigned T_POWERUP_DEF = 2_000_000;
  localparam int unsigned T_SETUP_DEF   = 3;
  localparam int unsigned T_EN_DEF      = 12;
  localparam int unsigned T_HOLD_DEF    = 3;
  localparam int unsigned T_CMD_DEF     = 2_500;
  localparam int unsigned T_LONG_DEF    = 100_000;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5
  } lcd_state_e;

  // Clear display (0x01) and return home (0x02/0x03) need the 2 ms wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded count.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic             Clock,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // A load of N followed by N-1 decrements reaches 1 on the Nth cycle.
  assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780-style write scheduler: arbitrates two requesters (0 has priority)
// and times RS/DB setup, EN pulse, hold and the post-write busy wait.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = T_POWERUP_DEF,
  parameter int unsigned T_SETUP   = T_SETUP_DEF,
  parameter int unsigned T_EN      = T_EN_DEF,
  parameter int unsigned T_HOLD    = T_HOLD_DEF,
  parameter int unsigned T_CMD     = T_CMD_DEF,
  parameter int unsigned T_LONG    = T_LONG_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DADOS,
  output logic       busy,
  output logic       powerup_done,
  output lcd_state_e dbg_state
);

  // Handshake: a write is taken at the rising edge of any cycle where
  // valid && ready; ready is only offered in IDLE and never waits on valid.

  lcd_state_e       state_q;
  logic             en_q, rs_q, long_q, busy_q, pud_q;
  logic [7:0]       data_q;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_value;

  lcd_timer u_timer (
    .Clock      (Clock),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // Timer reload on every state entry; IDLE is untimed and parks at zero.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (Reset) begin
      tmr_load  = 1'b1;
      tmr_value = CNT_W'(T_POWERUP);
    end else begin
      case (state_q)
        ST_POWERUP, ST_WAIT: tmr_load = tmr_done;
        ST_IDLE: begin
          tmr_load  = req0_valid | req1_valid;
          tmr_value = CNT_W'(T_SETUP);
        end
        ST_SETUP: begin
          tmr_load  = tmr_done;
          tmr_value = CNT_W'(T_EN);
        end
        ST_PULSE: begin
          tmr_load  = tmr_done;
          tmr_value = CNT_W'(T_HOLD);
        end
        ST_HOLD: begin
          tmr_load  = tmr_done;
          tmr_value = long_q ? CNT_W'(T_LONG) : CNT_W'(T_CMD);
        end
        default: begin
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(T_POWERUP);
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_POWERUP;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
      busy_q  <= 1'b1;
      pud_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_POWERUP: if (tmr_done) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          pud_q   <= 1'b1;
        end
        ST_IDLE: if (req0_valid) begin
          state_q <= ST_SETUP;
          busy_q  <= 1'b1;
          rs_q    <= req0_rs;
          data_q  <= req0_data;
          long_q  <= is_long_cmd(req0_rs, req0_data);
        end else if (req1_valid) begin
          state_q <= ST_SETUP;
          busy_q  <= 1'b1;
          rs_q    <= req1_rs;
          data_q  <= req1_data;
          long_q  <= is_long_cmd(req1_rs, req1_data);
        end
        ST_SETUP: if (tmr_done) begin
          state_q <= ST_PULSE;
          en_q    <= 1'b1;
        end
        ST_PULSE: if (tmr_done) begin
          state_q <= ST_HOLD;
          en_q    <= 1'b0;
        end
        ST_HOLD: if (tmr_done) state_q <= ST_WAIT;
        ST_WAIT: if (tmr_done) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_POWERUP;
          en_q    <= 1'b0;
          busy_q  <= 1'b1;
          pud_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready   = (state_q == ST_IDLE);
  assign req1_ready   = (state_q == ST_IDLE) && !req0_valid;
  assign LCD_EN       = en_q;
  assign LCD_RS       = rs_q;
  assign LCD_RW       = 1'b0;
  assign LCD_DADOS    = data_q;
  assign busy         = busy_q;
  assign powerup_done = pud_q;
  assign dbg_state    = state_q;

endmodule
